// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encodings, requester IDs and default widths for mem_arbiter
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic REQ_CORE   = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-way one-hot grant; round-robin when MEM_ARB_RR_EN is defined,
// fixed priority (requester 0 wins) otherwise
module rr_arbiter_2
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_last,
  input  logic       i_en,
  output logic [1:0] o_grant
);

  logic [1:0] w_grant;

`ifdef MEM_ARB_RR_EN
  always_comb begin
    w_grant = i_valid;
    // On contention the requester that was not granted last time wins.
    if (i_valid == 2'b11) begin
      w_grant = (i_last == REQ_CORE) ? 2'b10 : 2'b01;
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = i_last;

  always_comb begin
    w_grant = 2'b00;
    if (i_valid[0]) begin
      w_grant = 2'b01;
    end else if (i_valid[1]) begin
      w_grant = 2'b10;
    end
  end
`endif

  assign o_grant = i_en ? w_grant : 2'b00;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - core/loader arbiter over one synchronous-read memory, 3-cycle access;
// grant policy selected by MEM_ARB_RR_EN
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_r0_req_valid,
  output logic              o_r0_req_ready,
  input  logic              i_r0_req_we,
  input  logic [ADDR_W-1:0] i_r0_req_addr,
  input  logic [DATA_W-1:0] i_r0_req_wdata,
  output logic              o_r0_rsp_valid,
  output logic [DATA_W-1:0] o_r0_rsp_rdata,
  input  logic              i_r1_req_valid,
  output logic              o_r1_req_ready,
  input  logic              i_r1_req_we,
  input  logic [ADDR_W-1:0] i_r1_req_addr,
  input  logic [DATA_W-1:0] i_r1_req_wdata,
  output logic              o_r1_rsp_valid,
  output logic [DATA_W-1:0] o_r1_rsp_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  state_t            r_state;
  logic              r_owner;
  logic              r_we;
  logic              r_last;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_mem_en;
  logic              r_mem_we;
  logic              r_rsp0;
  logic              r_rsp1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic [1:0]        w_grant;
  logic              w_arb_en;
  logic              w_accept;
  logic              w_sel;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic [DATA_W-1:0] w_rsp_data;

  // Ready is suppressed while reset is held so nothing is accepted during reset.
  assign w_arb_en = (r_state == IDLE) && i_rst;

  rr_arbiter_2 u_arb (
    .i_valid ({i_r1_req_valid, i_r0_req_valid}),
    .i_last  (r_last),
    .i_en    (w_arb_en),
    .o_grant (w_grant)
  );

  assign w_accept    = |w_grant;
  assign w_sel       = w_grant[1];
  assign w_sel_we    = w_sel ? i_r1_req_we    : i_r0_req_we;
  assign w_sel_addr  = w_sel ? i_r1_req_addr  : i_r0_req_addr;
  assign w_sel_wdata = w_sel ? i_r1_req_wdata : i_r0_req_wdata;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state  <= IDLE;
      r_owner  <= REQ_CORE;
      r_we     <= 1'b0;
      r_last   <= REQ_LOADER;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      r_rsp0   <= 1'b0;
      r_rsp1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_rsp0 <= 1'b0;
      r_rsp1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_owner  <= w_sel;
            r_last   <= w_sel;
            r_we     <= w_sel_we;
            r_addr   <= w_sel_addr;
            r_wdata  <= w_sel_wdata;
            r_mem_en <= 1'b1;
            r_mem_we <= w_sel_we;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          r_rsp0   <= (r_owner == REQ_CORE);
          r_rsp1   <= (r_owner == REQ_LOADER);
          r_state  <= WAIT;
        end
        WAIT: begin
          if (r_rsp0) r_rdata0 <= w_rsp_data;
          if (r_rsp1) r_rdata1 <= w_rsp_data;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory data only arrives during WAIT, so it is forwarded while the pulse is up and held afterwards.
  assign w_rsp_data = r_we ? '0 : i_mem_rdata;

  assign o_r0_req_ready = w_grant[0];
  assign o_r1_req_ready = w_grant[1];
  assign o_r0_rsp_valid = r_rsp0;
  assign o_r1_rsp_valid = r_rsp1;
  assign o_r0_rsp_rdata = r_rsp0 ? w_rsp_data : r_rdata0;
  assign o_r1_rsp_rdata = r_rsp1 ? w_rsp_data : r_rdata1;
  assign o_mem_en       = r_mem_en;
  assign o_mem_we       = r_mem_we;
  assign o_mem_addr     = r_addr;
  assign o_mem_wdata    = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter with a timestamp-based reference model
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0_valid = 1'b0, r0_we = 1'b0;
  logic [31:0] r0_addr = '0, r0_wdata = '0;
  logic        r1_valid = 1'b0, r1_we = 1'b0;
  logic [31:0] r1_addr = '0, r1_wdata = '0;
  logic        r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid;
  logic [31:0] r0_rsp_rdata, r1_rsp_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  int          m_last = -10;
  logic        m_ptr = 1'b1, m_owner = 1'b0, m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_hold0 = '0, m_hold1 = '0;

  mem_arbiter dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_r0_req_valid (r0_valid),
    .o_r0_req_ready (r0_ready),
    .i_r0_req_we    (r0_we),
    .i_r0_req_addr  (r0_addr),
    .i_r0_req_wdata (r0_wdata),
    .o_r0_rsp_valid (r0_rsp_valid),
    .o_r0_rsp_rdata (r0_rsp_rdata),
    .i_r1_req_valid (r1_valid),
    .o_r1_req_ready (r1_ready),
    .i_r1_req_we    (r1_we),
    .i_r1_req_addr  (r1_addr),
    .i_r1_req_wdata (r1_wdata),
    .o_r1_rsp_valid (r1_rsp_valid),
    .o_r1_rsp_rdata (r1_rsp_rdata),
    .o_mem_en       (mem_en),
    .o_mem_we       (mem_we),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .i_mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) env_mem[mem_addr] = mem_wdata;
      else mem_rdata <= env_mem.exists(mem_addr) ? env_mem[mem_addr] : 32'h0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] exp_grant(input logic v0, input logic v1, input logic ptr);
    if (v0 && v1) return (RR && !ptr) ? 2'b10 : 2'b01;
    return {v1, v0};
  endfunction

  // Model: a request accepted in cycle T owns the memory in T+1 and answers in T+2.
  always @(negedge clk) begin
    logic [1:0]  g;
    logic        busy;
    logic [31:0] rexp;
    if (!rst) begin
      chk("rst_r0_ready", r0_ready, 0);
      chk("rst_r1_ready", r1_ready, 0);
      chk("rst_r0_rsp_valid", r0_rsp_valid, 0);
      chk("rst_r1_rsp_valid", r1_rsp_valid, 0);
      chk("rst_r0_rdata", r0_rsp_rdata, 0);
      chk("rst_r1_rdata", r1_rsp_rdata, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      m_last  = -10;
      m_ptr   = 1'b1;
      m_hold0 = '0;
      m_hold1 = '0;
    end else begin
      busy = (cyc == m_last + 1) || (cyc == m_last + 2);
      g = busy ? 2'b00 : exp_grant(r0_valid, r1_valid, m_ptr);
      chk("r0_ready", r0_ready, g[0]);
      chk("r1_ready", r1_ready, g[1]);
      chk("mem_en", mem_en, (cyc == m_last + 1));
      if (cyc == m_last + 1) begin
        chk("mem_we", mem_we, m_we);
        chk("mem_addr", mem_addr, m_addr);
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        if (m_we) ref_mem[m_addr] = m_wdata;
      end
      if (cyc == m_last + 2) begin
        rexp = m_we ? 32'h0 : (ref_mem.exists(m_addr) ? ref_mem[m_addr] : 32'h0);
        if (m_owner) m_hold1 = rexp;
        else m_hold0 = rexp;
      end
      chk("r0_rsp_valid", r0_rsp_valid, (cyc == m_last + 2) && !m_owner);
      chk("r1_rsp_valid", r1_rsp_valid, (cyc == m_last + 2) && m_owner);
      chk("r0_rsp_rdata", r0_rsp_rdata, m_hold0);
      chk("r1_rsp_rdata", r1_rsp_rdata, m_hold1);
      if (g != 2'b00) begin
        m_last  = cyc;
        m_owner = g[1];
        m_we    = g[1] ? r1_we : r0_we;
        m_addr  = g[1] ? r1_addr : r0_addr;
        m_wdata = g[1] ? r1_wdata : r0_wdata;
        m_ptr   = g[1];
      end
    end
  end

  task automatic do_req(input logic id, input logic we, input logic [31:0] a, input logic [31:0] d,
                        output int t);
    bit ok;
    ok = 1'b0;
    t = -1;
    @(posedge clk); #1;
    if (id) begin r1_valid = 1; r1_we = we; r1_addr = a; r1_wdata = d; end
    else begin r0_valid = 1; r0_we = we; r0_addr = a; r0_wdata = d; end
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if ((id ? r1_ready : r0_ready) === 1'b1) begin
        ok = 1'b1;
        t = cyc;
      end
    end
    chk("req_accept_in_time", ok, 1);
    @(posedge clk); #1;
    if (id) r1_valid = 0;
    else r0_valid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, r1_ready_cnt;
    int gq[$];
    int acc[$];
    int exp_g[4];
    bit just_r0;

    // Reset held with both requesters asking.
    r0_valid = 1; r1_valid = 1;
    #2 rst = 0;
    repeat (3) @(negedge clk);
    chk("reset_no_ready", {r1_ready, r0_ready}, 2'b00);
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    chk("release_r0_ready", r0_ready, 1);
    chk("release_r1_ready", r1_ready, 0);
    @(posedge clk); #1;
    r0_valid = 0; r1_valid = 0;
    repeat (3) @(posedge clk);

    // Write then read back through r0.
    do_req(0, 1, 32'h10, 32'hDEADBEEF, t0);
    @(negedge clk);
    chk("wr_mem_en", mem_en, 1);
    chk("wr_mem_addr", mem_addr, 32'h10);
    @(negedge clk);
    chk("wr_rsp_valid", r0_rsp_valid, 1);
    chk("wr_rsp_rdata", r0_rsp_rdata, 32'h0);
    do_req(0, 0, 32'h10, 32'h0, t1);
    chk("rd_accept_gap", t1 - t0, 3);
    @(negedge clk);
    @(negedge clk);
    chk("rd_rsp_valid", r0_rsp_valid, 1);
    chk("rd_rsp_rdata", r0_rsp_rdata, 32'hDEADBEEF);
    chk("rd_r1_quiet", r1_rsp_valid, 0);

    // Contention from a fresh reset.
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1 rst = 1;
    r0_we = 1; r0_addr = 32'h40; r0_wdata = 32'hA0; r0_valid = 1;
    r1_we = 0; r1_addr = 32'h40; r1_wdata = 32'h0;  r1_valid = 1;
    r1_ready_cnt = 0;
    for (int k = 0; k < 30 && gq.size() < 4; k++) begin
      @(negedge clk);
      just_r0 = 1'b0;
      if (r0_ready) begin gq.push_back(0); just_r0 = 1'b1; end
      if (r1_ready) begin gq.push_back(1); r1_ready_cnt++; end
      @(posedge clk); #1;
      if (just_r0) r0_wdata = r0_wdata + 1;
    end
    r0_valid = 0; r1_valid = 0;
    if (RR) exp_g = '{0, 1, 0, 1};
    else exp_g = '{0, 0, 0, 0};
    chk("cont_grant_count", gq.size(), 4);
    for (int i = 0; i < gq.size() && i < 4; i++) chk("cont_grant_order", gq[i], exp_g[i]);
    chk("cont_r1_ready_cycles", r1_ready_cnt, RR ? 2 : 0);
    repeat (3) @(negedge clk);
    chk("cont_r1_rdata", r1_rsp_rdata, RR ? 32'hA1 : 32'h0);
    chk("cont_r0_rdata", r0_rsp_rdata, 32'h0);

    // Back-to-back loader reads.
    @(posedge clk); #1;
    r1_we = 0; r1_addr = 32'h10; r1_valid = 1;
    for (int k = 0; k < 20 && acc.size() < 3; k++) begin
      @(negedge clk);
      if (r1_ready) acc.push_back(cyc);
    end
    @(posedge clk); #1 r1_valid = 0;
    chk("b2b_count", acc.size(), 3);
    if (acc.size() == 3) begin
      chk("b2b_gap0", acc[1] - acc[0], 3);
      chk("b2b_gap1", acc[2] - acc[1], 3);
    end
    repeat (3) @(negedge clk);
    chk("b2b_r1_rdata", r1_rsp_rdata, 32'hDEADBEEF);

    // Reset during the ISSUE cycle of a loader write.
    do_req(1, 1, 32'h20, 32'h5A5A5A5A, t0);
    rst = 0;
    @(negedge clk);
    chk("midrst_mem_en", mem_en, 0);
    repeat (2) @(negedge clk);
    chk("midrst_no_rsp", r1_rsp_valid, 0);
    @(posedge clk); #1 rst = 1;
    chk("midrst_no_write", env_mem.exists(32'h20), 0);
    do_req(1, 0, 32'h20, 32'h0, t1);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_next_rsp", r1_rsp_valid, 1);
    chk("midrst_next_rdata", r1_rsp_rdata, 32'h0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
